wb_ram_arbiter: RTL and testbench
=================================

WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, range 1..65535; slave-response timeout in cycles.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have master-side inputs, 3 masters packed, master n in slice n (m0 = or1k_i, m1 = or1k_d, m2 = dbg):
- m_adr_i  in  3*AW  address.
- m_dat_i  in  3*DW  write data.
- m_sel_i  in  3*DW/8  byte select.
- m_we_i, m_cyc_i, m_stb_i  in  3 each  write enable, cycle, strobe.
- m_cti_i  in  9  cycle type.
- m_bte_i  in  6  burst type.
REQ-007 SHALL have master-side outputs:
- m_dat_o  out  3*DW  read data.
- m_ack_o, m_err_o, m_rty_o  out  3 each  terminations.
REQ-008 SHALL have slave-side outputs, one bit each unless noted:
- s_adr_o  out  AW.
- s_dat_o  out  DW.
- s_sel_o  out  DW/8.
- s_we_o, s_cyc_o, s_stb_o  out.
- s_cti_o  out  3.
- s_bte_o  out  2.
REQ-009 SHALL have slave-side inputs: s_dat_i  in  DW; s_ack_i, s_err_i, s_rty_i  in  1 each.

Function
REQ-010 SHALL implement FSM states IDLE and BUSY, plus registers grant[1:0] and last[1:0].
REQ-011 In IDLE with any m_cyc_i high, SHALL select by round robin, searching from index (last+1) mod 3 upward with wrap; next cycle SHALL be BUSY with grant set to the selected index.
REQ-012 SHALL have an arbitration latency of exactly 1 cycle: the slave sees the winner's cyc no earlier than the cycle after the request is first sampled in IDLE.
REQ-013 In IDLE, SHALL hold s_cyc_o and s_stb_o at 0; other s_* outputs are don't-care.
REQ-014 In BUSY, SHALL route s_adr/dat/sel/we/cti/bte_o combinationally from master grant; s_cyc_o = m_cyc_i[grant]; s_stb_o = m_stb_i[grant] & ~abort.
REQ-015 In BUSY, SHALL route s_ack_i/s_err_i/s_rty_i combinationally to the granted master only; non-granted masters SHALL see ack/err/rty = 0.
REQ-016 SHALL drive m_dat_o = s_dat_i on all three slices.
REQ-017 Ownership SHALL persist across any number of transfers and bursts while m_cyc_i[grant] stays high; cti/bte SHALL be passed through unmodified.
REQ-018 In BUSY with m_cyc_i[grant] low, SHALL go to IDLE next cycle and set last <= grant.
REQ-019 SHALL always insert at least one IDLE cycle between consecutive ownerships.
REQ-020 SHALL have a 16-bit timeout counter that increments each BUSY cycle in which s_stb_o=1 and s_ack_i|s_err_i|s_rty_i=0, and clears on any slave termination or in IDLE.
REQ-021 When the counter equals TIMEOUT, abort SHALL assert for that cycle: m_err_o[grant]=1, s_stb_o=0, counter cleared next cycle; ownership SHALL be retained.
REQ-022 If a slave termination arrives in the same cycle the counter equals TIMEOUT, the slave termination SHALL win: no abort, no extra err.
REQ-023 If m_cyc_i[grant] drops during a pending wait, SHALL release per REQ-018; the counter SHALL clear and no err SHALL be issued.
REQ-024 Requests from masters that are not granted SHALL be held off (no termination) indefinitely until granted; no request is ever dropped.

Reset
REQ-025 While wb_rst_i=1 at a clock edge, SHALL set state=IDLE, grant=0, last=2 (so m0 wins first), counter=0.
REQ-026 During and after reset, SHALL have s_cyc_o=0, s_stb_o=0, all m_ack/err/rty_o=0; this SHALL also hold when reset asserts mid-transfer.

Verification
REQ-027 SHALL verify: after reset, m0, m1 and m2 cyc rise together -> grants in order m0, m1, m2, each separated by 1 IDLE cycle; m1 s_cyc_o rises exactly 1 cycle after m0 cyc drops + 1.
REQ-028 SHALL verify: m1 owns the bus doing a 4-beat incrementing burst (cti 010, 010, 010, 111) while m2 requests -> all 4 acks go to m1 only; m2 is granted only after m1 cyc drops.
REQ-029 SHALL verify: TIMEOUT=4, slave never acks -> m_err_o[grant] pulses in the 5th stb cycle with s_stb_o=0 that cycle; the master retains ownership.
REQ-030 SHALL verify: TIMEOUT=4, s_ack_i arrives in the same cycle the counter reaches 4 -> ack only, no err.
REQ-031 SHALL verify: wb_rst_i asserted mid-burst by m1 -> next cycle s_cyc_o=0; afterwards, with m1 and m2 requesting, m1 is granted first (last=2).
REQ-032 SHALL verify: with m0 holding cyc continuously and m2 requesting, m2 gets no termination until m0 releases, then is granted exactly 2 cycles after release.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : wb_ram_arbiter
// Function : three-master round-robin Wishbone arbiter with slave-response timeout
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_ram_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // master side, master n in slice n
  input  logic [3*AW-1:0]   m_adr_i,
  input  logic [3*DW-1:0]   m_dat_i,
  input  logic [3*DW/8-1:0] m_sel_i,
  input  logic [2:0]        m_we_i,
  input  logic [2:0]        m_cyc_i,
  input  logic [2:0]        m_stb_i,
  input  logic [8:0]        m_cti_i,
  input  logic [5:0]        m_bte_i,
  output logic [3*DW-1:0]   m_dat_o,
  output logic [2:0]        m_ack_o,
  output logic [2:0]        m_err_o,
  output logic [2:0]        m_rty_o,
  // slave side
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i
);

  localparam int          c_sw      = DW / 8;
  localparam logic [15:0] c_timeout = 16'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_grant;
  logic [1:0]  r_last;
  logic [15:0] r_cnt;

  logic        w_busy;
  logic        w_gcyc;
  logic        w_gstb;
  logic        w_term;
  logic        w_abort;
  logic [1:0]  w_c0;
  logic [1:0]  w_c1;
  logic [1:0]  w_c2;
  logic [1:0]  w_sel;

  // Reset gates the bus immediately, even in the cycle it is first asserted.
  assign w_busy  = (r_state == ST_BUSY) && !wb_rst_i;
  assign w_gcyc  = m_cyc_i[r_grant];
  assign w_gstb  = m_stb_i[r_grant];
  assign w_term  = s_ack_i | s_err_i | s_rty_i;
  assign w_abort = w_busy & w_gcyc & w_gstb & ~w_term & (r_cnt == c_timeout);

  // Round-robin candidate order starting just after the last owner.
  assign w_c0 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
  assign w_c1 = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
  assign w_c2 = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;

  always_comb begin
    if (m_cyc_i[w_c0])
      w_sel = w_c0;
    else if (m_cyc_i[w_c1])
      w_sel = w_c1;
    else
      w_sel = w_c2;
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    for (int i = 0; i < 3; i++) begin
      if (r_grant == 2'(i)) begin
        s_adr_o = m_adr_i[i*AW +: AW];
        s_dat_o = m_dat_i[i*DW +: DW];
        s_sel_o = m_sel_i[i*c_sw +: c_sw];
        s_we_o  = m_we_i[i];
        s_cti_o = m_cti_i[i*3 +: 3];
        s_bte_o = m_bte_i[i*2 +: 2];
      end
    end
  end

  assign s_cyc_o = w_busy & w_gcyc;
  assign s_stb_o = w_busy & w_gstb & ~w_abort;
  assign m_dat_o = {3{s_dat_i}};

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (w_busy) begin
      m_ack_o[r_grant] = s_ack_i;
      m_err_o[r_grant] = s_err_i | w_abort;
      m_rty_o[r_grant] = s_rty_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= 2'd0;
      r_last  <= 2'd2;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (|m_cyc_i) begin
            r_state <= ST_BUSY;
            r_grant <= w_sel;
          end
        end
        ST_BUSY: begin
          if (!w_gcyc) begin
            r_state <= ST_IDLE;
            r_last  <= r_grant;
            r_cnt   <= '0;
          end else if (w_term || w_abort) begin
            r_cnt <= '0;
          end else if (w_gstb) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_ram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_wb_ram_arbiter
// Function : directed self-checking bench for wb_ram_arbiter (TIMEOUT = 4)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [3*AW-1:0]   m_adr_i;
  logic [3*DW-1:0]   m_dat_i;
  logic [3*DW/8-1:0] m_sel_i;
  logic [2:0]        m_we_i, m_cyc_i, m_stb_i;
  logic [8:0]        m_cti_i;
  logic [5:0]        m_bte_i;
  logic [3*DW-1:0]   m_dat_o;
  logic [2:0]        m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] c_adr0 = 32'h0000_1000;
  localparam logic [31:0] c_adr1 = 32'h1000_0000;
  localparam logic [31:0] c_adr2 = 32'h2000_0000;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic req(input logic [2:0] v);
    m_cyc_i = v;
    m_stb_i = v;
  endtask

  initial begin
    logic [2:0] ctis [4];
    ctis = '{3'b010, 3'b010, 3'b010, 3'b111};

    wb_rst_i = 1'b1;
    m_adr_i  = {c_adr2, c_adr1, c_adr0};
    m_dat_i  = {32'hCCCC_2222, 32'hBBBB_1111, 32'hAAAA_0000};
    m_sel_i  = {4'hC, 4'h3, 4'hF};
    m_we_i   = 3'b010;
    m_cti_i  = '0;
    m_bte_i  = {2'b00, 2'b01, 2'b00};
    s_dat_i  = 32'h5A5A_0001;
    s_ack_i  = 1'b0;
    s_err_i  = 1'b0;
    s_rty_i  = 1'b0;
    req(3'b000);

    // reset
    step();
    step();
    settle();
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_ack", m_ack_o, 0);
    wb_rst_i = 1'b0;

    // all three request together: m0, m1, m2 in turn with an IDLE gap
    req(3'b111);
    settle();
    chk("arb_latency", s_cyc_o, 0);
    step();
    settle();
    chk("g0_cyc", s_cyc_o, 1);
    chk("g0_adr", s_adr_o, c_adr0);
    s_ack_i = 1'b1;
    settle();
    chk("g0_ack", m_ack_o, 3'b001);
    chk("dat_o", m_dat_o[95:64], 32'h5A5A_0001);
    s_ack_i = 1'b0;
    req(3'b110);
    settle();
    chk("g0_release_cyc", s_cyc_o, 0);
    step();
    settle();
    chk("gap1_cyc", s_cyc_o, 0);
    step();
    settle();
    chk("g1_cyc", s_cyc_o, 1);
    chk("g1_adr", s_adr_o, c_adr1);
    req(3'b100);
    step();
    settle();
    chk("gap2_cyc", s_cyc_o, 0);
    step();
    settle();
    chk("g2_adr", s_adr_o, c_adr2);
    req(3'b000);
    step();

    // m1 4-beat incrementing burst while m2 waits
    req(3'b110);
    step();
    settle();
    chk("burst_owner", s_adr_o, c_adr1);
    chk("burst_we", s_we_o, 1);
    chk("burst_dat", s_dat_o, 32'hBBBB_1111);
    chk("burst_sel", s_sel_o, 4'h3);
    chk("burst_bte", s_bte_o, 2'b01);
    for (int b = 0; b < 4; b++) begin
      m_cti_i[5:3] = ctis[b];
      s_ack_i = 1'b1;
      settle();
      chk("burst_ack", m_ack_o, 3'b010);
      chk("burst_cti", s_cti_o, ctis[b]);
      step();
    end
    s_ack_i = 1'b0;
    m_cti_i = '0;
    req(3'b100);
    settle();
    chk("burst_end_ack", m_ack_o, 0);
    step();
    settle();
    chk("burst_gap", s_cyc_o, 0);
    step();
    settle();
    chk("m2_after_burst", s_adr_o, c_adr2);
    chk("m2_after_burst_cyc", s_cyc_o, 1);
    req(3'b000);
    step();

    // timeout: slave silent, err in the 5th stb cycle, ownership kept
    req(3'b001);
    step();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("to_wait_err", m_err_o, 0);
      chk("to_wait_stb", s_stb_o, 1);
      step();
    end
    settle();
    chk("to_err", m_err_o, 3'b001);
    chk("to_stb", s_stb_o, 0);
    chk("to_cyc", s_cyc_o, 1);
    step();
    settle();
    chk("to_after_err", m_err_o, 0);
    chk("to_after_stb", s_stb_o, 1);
    chk("to_after_adr", s_adr_o, c_adr0);

    // ack in the same cycle the counter reaches TIMEOUT
    step();
    step();
    step();
    step();
    s_ack_i = 1'b1;
    settle();
    chk("tie_ack", m_ack_o, 3'b001);
    chk("tie_err", m_err_o, 0);
    chk("tie_stb", s_stb_o, 1);
    step();
    s_ack_i = 1'b0;
    req(3'b000);
    step();

    // reset mid-burst by m1, with m1 the previous owner
    req(3'b010);
    step();
    req(3'b000);
    step();
    req(3'b010);
    step();
    settle();
    chk("rb_owner", s_adr_o, c_adr1);
    m_cti_i[5:3] = 3'b010;
    s_ack_i = 1'b1;
    step();
    wb_rst_i = 1'b1;
    settle();
    chk("rb_during_cyc", s_cyc_o, 0);
    chk("rb_during_ack", m_ack_o, 0);
    step();
    wb_rst_i = 1'b0;
    s_ack_i = 1'b0;
    m_cti_i = '0;
    req(3'b110);
    settle();
    chk("rb_after_cyc", s_cyc_o, 0);
    step();
    settle();
    chk("rb_first_grant", s_adr_o, c_adr1);
    req(3'b000);
    step();

    // m0 holds the bus while m2 waits
    req(3'b001);
    step();
    req(3'b101);
    s_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_ack", m_ack_o, 3'b001);
      step();
    end
    s_ack_i = 1'b0;
    s_err_i = 1'b1;
    settle();
    chk("hold_err", m_err_o, 3'b001);
    s_err_i = 1'b0;
    req(3'b100);
    settle();
    chk("hold_release", s_cyc_o, 0);
    step();
    settle();
    chk("hold_gap", s_cyc_o, 0);
    step();
    settle();
    chk("hold_m2_cyc", s_cyc_o, 1);
    chk("hold_m2_adr", s_adr_o, c_adr2);
    s_rty_i = 1'b1;
    settle();
    chk("m2_rty", m_rty_o, 3'b100);
    s_rty_i = 1'b0;
    req(3'b000);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
